// File: rtl/regfile_arbiter.sv
// Two-requester arbiter and access sequencer for the 16 x 16-bit register file.
// Grants alternate on ties; every register-file control, address and data output is driven from a flop.
module regfile_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_ra,
  input  logic [ADDR_W-1:0] p0_rb,
  input  logic [ADDR_W-1:0] p0_rw,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata_a,
  output logic [DATA_W-1:0] p0_rdata_b,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_ra,
  input  logic [ADDR_W-1:0] p1_rb,
  input  logic [ADDR_W-1:0] p1_rw,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata_a,
  output logic [DATA_W-1:0] p1_rdata_b,
  output logic              rf_en,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_ra,
  output logic [ADDR_W-1:0] rf_rb,
  output logic [ADDR_W-1:0] rf_rw,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_bus_a,
  input  logic [DATA_W-1:0] rf_bus_b,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, RD, RD_CAP, WR_SETUP, WR_PULSE, WR_HOLD, RESP
  } state_t;

  state_t state, state_n;

  logic              last_grant;
  logic              gid;
  logic              grant;
  logic              grant_id;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_ra;
  logic [ADDR_W-1:0] sel_rb;
  logic [ADDR_W-1:0] sel_rw;
  logic [DATA_W-1:0] sel_wdata;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    grant    = 1'b0;
    grant_id = 1'b0;
    if (state == IDLE) begin
      if (p0_req && p1_req) begin
        grant    = 1'b1;
        grant_id = ~last_grant;
      end else if (p0_req) begin
        grant    = 1'b1;
        grant_id = 1'b0;
      end else if (p1_req) begin
        grant    = 1'b1;
        grant_id = 1'b1;
      end
    end
  end

  always_comb begin
    sel_we    = grant_id ? p1_we    : p0_we;
    sel_ra    = grant_id ? p1_ra    : p0_ra;
    sel_rb    = grant_id ? p1_rb    : p0_rb;
    sel_rw    = grant_id ? p1_rw    : p0_rw;
    sel_wdata = grant_id ? p1_wdata : p0_wdata;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (grant) state_n = sel_we ? WR_SETUP : RD;
      RD:       state_n = RD_CAP;
      RD_CAP:   state_n = RESP;
      WR_SETUP: state_n = WR_PULSE;
      WR_PULSE: state_n = WR_HOLD;
      WR_HOLD:  state_n = RESP;
      RESP:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      gid        <= 1'b0;
      rf_en      <= 1'b0;
      rf_we      <= 1'b0;
      rf_ra      <= '0;
      rf_rb      <= '0;
      rf_rw      <= '0;
      rf_wdata   <= '0;
      p0_ack     <= 1'b0;
      p1_ack     <= 1'b0;
      p0_rdata_a <= '0;
      p0_rdata_b <= '0;
      p1_rdata_a <= '0;
      p1_rdata_b <= '0;
      busy       <= 1'b0;
    end else begin
      if (grant) begin
        last_grant <= grant_id;
        gid        <= grant_id;
        rf_ra      <= sel_ra;
        rf_rb      <= sel_rb;
        rf_rw      <= sel_rw;
        rf_wdata   <= sel_wdata;
      end
      rf_en  <= (state_n == RD) || (state_n == WR_SETUP) ||
                (state_n == WR_PULSE) || (state_n == WR_HOLD);
      rf_we  <= (state_n == WR_PULSE);
      p0_ack <= (state_n == RESP) && !gid;
      p1_ack <= (state_n == RESP) && gid;
      busy   <= (state_n != IDLE);
      if (state == RD_CAP) begin
        if (gid) begin
          p1_rdata_a <= rf_bus_a;
          p1_rdata_b <= rf_bus_b;
        end else begin
          p0_rdata_a <= rf_bus_a;
          p0_rdata_b <= rf_bus_b;
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register file
// whose register i starts out holding i+1.
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [3:0]  p0_ra, p0_rb, p0_rw, p1_ra, p1_rb, p1_rw;
  logic [15:0] p0_wdata, p1_wdata;
  logic        p0_ack, p1_ack;
  logic [15:0] p0_rdata_a, p0_rdata_b, p1_rdata_a, p1_rdata_b;
  logic        rf_en, rf_we, busy;
  logic [3:0]  rf_ra, rf_rb, rf_rw;
  logic [15:0] rf_wdata;
  logic [15:0] rf_bus_a = '0, rf_bus_b = '0;
  logic [15:0] mem [16];

  int vectors = 0;
  int miscompares = 0;

  regfile_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_ra(p0_ra), .p0_rb(p0_rb), .p0_rw(p0_rw),
    .p0_wdata(p0_wdata), .p0_ack(p0_ack), .p0_rdata_a(p0_rdata_a), .p0_rdata_b(p0_rdata_b),
    .p1_req(p1_req), .p1_we(p1_we), .p1_ra(p1_ra), .p1_rb(p1_rb), .p1_rw(p1_rw),
    .p1_wdata(p1_wdata), .p1_ack(p1_ack), .p1_rdata_a(p1_rdata_a), .p1_rdata_b(p1_rdata_b),
    .rf_en(rf_en), .rf_we(rf_we), .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rw(rf_rw),
    .rf_wdata(rf_wdata), .rf_bus_a(rf_bus_a), .rf_bus_b(rf_bus_b), .busy(busy)
  );

  always #5 clk = ~clk;

  // Register file: read buses and write both load on a clock edge while enabled.
  always @(posedge clk) begin
    if (rf_en) begin
      rf_bus_a <= mem[rf_ra];
      rf_bus_b <= mem[rf_rb];
      if (rf_we) mem[rf_rw] <= rf_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_ra = 0; p0_rb = 0; p0_rw = 0; p0_wdata = 0;
    p1_req = 0; p1_we = 0; p1_ra = 0; p1_rb = 0; p1_rw = 0; p1_wdata = 0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1;
    for (int i = 0; i < 16; i++) mem[i] = 16'(i + 1);
    @(posedge clk);
    #3 rst_n = 0;
    #1;
    vectors++;
    if ({p0_ack, p1_ack, rf_en, rf_we, busy} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b expected 00000", {p0_ack, p1_ack, rf_en, rf_we, busy});
    end
    vectors++;
    if ({p0_rdata_a, p0_rdata_b, p1_rdata_a, p1_rdata_b, rf_wdata} !== 80'h0 ||
        {rf_ra, rf_rb, rf_rw} !== 12'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h/%h expected 0", {p0_rdata_a, p0_rdata_b, p1_rdata_a, p1_rdata_b, rf_wdata}, {rf_ra, rf_rb, rf_rw});
    end
    tick();
    tick();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if ({p0_ack, p1_ack, busy} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL post_reset_idle: got %b expected 000", {p0_ack, p1_ack, busy});
      end
    end
  endtask

  task automatic test_read();
    p0_req = 1; p0_we = 0; p0_ra = 3; p0_rb = 7;
    tick();
    vectors++;
    if ({rf_en, rf_we, busy} !== 3'b101 || rf_ra !== 4'd3 || rf_rb !== 4'd7) begin
      miscompares++;
      $display("[TB] FAIL read_c1: got en/we/busy=%b ra=%0d rb=%0d expected 101 3 7", {rf_en, rf_we, busy}, rf_ra, rf_rb);
    end
    tick();
    vectors++;
    if ({rf_en, p0_ack, busy} !== 3'b001) begin
      miscompares++;
      $display("[TB] FAIL read_c2: got en/ack/busy=%b expected 001", {rf_en, p0_ack, busy});
    end
    tick();
    vectors++;
    if (p0_ack !== 1'b1 || p1_ack !== 1'b0 || p0_rdata_a !== 16'h0004 || p0_rdata_b !== 16'h0008) begin
      miscompares++;
      $display("[TB] FAIL read_ack: got ack=%b%b a=%h b=%h expected 10 0004 0008", p0_ack, p1_ack, p0_rdata_a, p0_rdata_b);
    end
    p0_req = 0;
    tick();
    vectors++;
    if ({p0_ack, busy} !== 2'b00 || p0_rdata_a !== 16'h0004 || p1_rdata_a !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL read_hold: got ack/busy=%b a=%h p1a=%h expected 00 0004 0000", {p0_ack, busy}, p0_rdata_a, p1_rdata_a);
    end
  endtask

  task automatic test_write_then_read();
    p1_req = 1; p1_we = 1; p1_rw = 5; p1_wdata = 16'hBEEF;
    tick();
    vectors++;
    if ({rf_en, rf_we} !== 2'b10 || rf_rw !== 4'd5 || rf_wdata !== 16'hBEEF) begin
      miscompares++;
      $display("[TB] FAIL wr_setup: got en/we=%b rw=%0d wd=%h expected 10 5 beef", {rf_en, rf_we}, rf_rw, rf_wdata);
    end
    tick();
    vectors++;
    if ({rf_en, rf_we} !== 2'b11 || rf_rw !== 4'd5 || rf_wdata !== 16'hBEEF) begin
      miscompares++;
      $display("[TB] FAIL wr_pulse: got en/we=%b rw=%0d wd=%h expected 11 5 beef", {rf_en, rf_we}, rf_rw, rf_wdata);
    end
    tick();
    vectors++;
    if ({rf_en, rf_we, p1_ack} !== 3'b100 || rf_rw !== 4'd5 || rf_wdata !== 16'hBEEF) begin
      miscompares++;
      $display("[TB] FAIL wr_hold: got en/we/ack=%b rw=%0d wd=%h expected 100 5 beef", {rf_en, rf_we, p1_ack}, rf_rw, rf_wdata);
    end
    tick();
    vectors++;
    if ({p1_ack, p0_ack, rf_en, rf_we} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL wr_ack: got p1ack/p0ack/en/we=%b expected 1000", {p1_ack, p0_ack, rf_en, rf_we});
    end
    p1_we = 0; p1_ra = 5; p1_rb = 5;
    tick();
    tick();
    tick();
    tick();
    vectors++;
    if (p1_ack !== 1'b1 || p1_rdata_a !== 16'hBEEF || p1_rdata_b !== 16'hBEEF || p0_rdata_a !== 16'h0004) begin
      miscompares++;
      $display("[TB] FAIL wr_readback: got ack=%b a=%h b=%h p0a=%h expected 1 beef beef 0004", p1_ack, p1_rdata_a, p1_rdata_b, p0_rdata_a);
    end
    p1_req = 0;
    tick();
  endtask

  task automatic test_tie();
    pulse_reset();
    p0_req = 1; p0_we = 0; p0_ra = 1;  p0_rb = 2;
    p1_req = 1; p1_we = 0; p1_ra = 10; p1_rb = 11;
    tick();
    tick();
    tick();
    vectors++;
    if ({p0_ack, p1_ack} !== 2'b10 || p0_rdata_a !== 16'h0002 || p0_rdata_b !== 16'h0003) begin
      miscompares++;
      $display("[TB] FAIL tie_first: got ack=%b%b a=%h b=%h expected 10 0002 0003", p0_ack, p1_ack, p0_rdata_a, p0_rdata_b);
    end
    p0_req = 0;
    tick();
    vectors++;
    if ({busy, p1_ack} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL tie_gap: got busy/ack=%b expected 00", {busy, p1_ack});
    end
    tick();
    vectors++;
    if ({busy, rf_en} !== 2'b11 || rf_ra !== 4'd10) begin
      miscompares++;
      $display("[TB] FAIL tie_second_grant: got busy/en=%b ra=%0d expected 11 10", {busy, rf_en}, rf_ra);
    end
    tick();
    tick();
    vectors++;
    if ({p0_ack, p1_ack} !== 2'b01 || p1_rdata_a !== 16'h000B || p1_rdata_b !== 16'h000C) begin
      miscompares++;
      $display("[TB] FAIL tie_second: got ack=%b%b a=%h b=%h expected 01 000b 000c", p0_ack, p1_ack, p1_rdata_a, p1_rdata_b);
    end
    p1_req = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    int k0 = 0;
    int k1 = 1;
    int n = 0;
    logic prev0 = 0;
    logic prev1 = 0;
    p0_req = 1; p0_we = 0; p0_ra = 4'(8 + k0); p0_rb = 4'(15 - k0);
    p1_req = 1; p1_we = 0; p1_ra = 4'(8 + k1); p1_rb = 4'(15 - k1);
    for (int c = 0; c < 200 && n < 8; c++) begin
      tick();
      if (p0_ack && p1_ack) begin
        vectors++; miscompares++;
        $display("[TB] FAIL b2b_double_ack: got both acks expected one");
      end
      if (p0_ack) begin
        vectors++;
        if (prev0 || (n % 2) != 0 || p0_rdata_a !== 16'(9 + k0) || p0_rdata_b !== 16'(16 - k0)) begin
          miscompares++;
          $display("[TB] FAIL b2b_p0 #%0d: got prev=%b a=%h b=%h expected 0 %h %h at even slot", n, prev0, p0_rdata_a, p0_rdata_b, 16'(9 + k0), 16'(16 - k0));
        end
        n++; k0 += 2;
        if (k0 >= 8) p0_req = 0;
        p0_ra = 4'(8 + k0); p0_rb = 4'(15 - k0);
      end
      if (p1_ack) begin
        vectors++;
        if (prev1 || (n % 2) != 1 || p1_rdata_a !== 16'(9 + k1) || p1_rdata_b !== 16'(16 - k1)) begin
          miscompares++;
          $display("[TB] FAIL b2b_p1 #%0d: got prev=%b a=%h b=%h expected 0 %h %h at odd slot", n, prev1, p1_rdata_a, p1_rdata_b, 16'(9 + k1), 16'(16 - k1));
        end
        n++; k1 += 2;
        if (k1 >= 8) p1_req = 0;
        p1_ra = 4'(8 + k1); p1_rb = 4'(15 - k1);
      end
      prev0 = p0_ack;
      prev1 = p1_ack;
    end
    vectors++;
    if (n != 8) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got %0d transactions expected 8", n);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_during_write();
    p0_req = 1; p0_we = 1; p0_rw = 9; p0_wdata = 16'h1234;
    tick();
    tick();
    #2 rst_n = 0;
    #1;
    vectors++;
    if ({rf_en, rf_we, busy, p0_ack} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL rst_mid_write: got en/we/busy/ack=%b expected 0000", {rf_en, rf_we, busy, p0_ack});
    end
    p0_req = 0;
    tick();
    rst_n = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if ({p0_ack, busy} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL rst_no_ack: got ack/busy=%b expected 00", {p0_ack, busy});
      end
    end
    p0_req = 1; p0_we = 1; p0_rw = 9; p0_wdata = 16'h5A5A;
    tick(); tick(); tick(); tick();
    vectors++;
    if (p0_ack !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rewrite_ack: got %b expected 1", p0_ack);
    end
    p0_we = 0; p0_ra = 9; p0_rb = 9;
    tick(); tick(); tick(); tick();
    vectors++;
    if (p0_ack !== 1'b1 || p0_rdata_a !== 16'h5A5A || p0_rdata_b !== 16'h5A5A) begin
      miscompares++;
      $display("[TB] FAIL rewrite_readback: got ack=%b a=%h b=%h expected 1 5a5a 5a5a", p0_ack, p0_rdata_a, p0_rdata_b);
    end
    p0_req = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_then_read();
    test_tie();
    test_back_to_back();
    test_reset_during_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
